// File: rtl/lenet_layer_sched.sv
// lenet_layer_sched: runs conv1 -> conv2 -> fc1 -> fc2 once per image for
// NUM_IMAGES images per start command, and owns the weight SRAM read port.
// Optional build macro: LENET_SCHED_TIMEOUT_EN adds a per-layer watchdog.
//
// state | meaning
// IDLE  | waiting for start; weight address parked at 0
// CONV1 | conv1 engine running
// CONV2 | conv2 engine running
// FC1   | fc1 engine running
// FC2   | fc2 engine running; last image returns to IDLE with done
module lenet_layer_sched #(
  parameter int CONV1_BASE     = 0,
  parameter int CONV2_BASE     = 21,
  parameter int FC1_BASE       = 1023,
  parameter int FC2_BASE       = 17023,
  parameter int CONV1_SIZE     = 21,
  parameter int CONV2_SIZE     = 1002,
  parameter int FC1_SIZE       = 16000,
  parameter int FC2_SIZE       = 200,
  parameter int NUM_IMAGES     = 1,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [2:0]  layer_id,
  output logic [15:0] image_cnt,
  output logic        conv1_start,
  output logic        conv2_start,
  output logic        fc1_start,
  output logic        fc2_start,
  input  logic        conv1_finish,
  input  logic        conv2_finish,
  input  logic        fc1_finish,
  input  logic        fc2_finish,
  input  logic [14:0] conv1_raddr_w,
  input  logic [14:0] conv2_raddr_w,
  input  logic [14:0] fc1_raddr_w,
  input  logic [14:0] fc2_raddr_w,
  output logic [16:0] sram_raddr_weight,
  output logic        addr_err,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV1 = 3'd1,
    CONV2 = 3'd2,
    FC1   = 3'd3,
    FC2   = 3'd4
  } state_t;

  localparam logic [15:0] LAST_IMG = 16'(NUM_IMAGES - 1);
  localparam logic [16:0] C1_BASE  = 17'(CONV1_BASE);
  localparam logic [16:0] C2_BASE  = 17'(CONV2_BASE);
  localparam logic [16:0] F1_BASE  = 17'(FC1_BASE);
  localparam logic [16:0] F2_BASE  = 17'(FC2_BASE);
  localparam logic [16:0] C1_SIZE  = 17'(CONV1_SIZE);
  localparam logic [16:0] C2_SIZE  = 17'(CONV2_SIZE);
  localparam logic [16:0] F1_SIZE  = 17'(FC1_SIZE);
  localparam logic [16:0] F2_SIZE  = 17'(FC2_SIZE);

  state_t      state, next_state;
  logic [3:0]  start_q, start_d;   // one-hot {fc2, fc1, conv2, conv1}
  logic        done_d;
  logic        img_inc;
  logic        batch_go;
  logic        act_fin;
  logic        fin_ok;
  logic        range_err;
  logic [14:0] loc_addr;
  logic [16:0] base, size;

`ifdef LENET_SCHED_TIMEOUT_EN
  localparam logic [17:0] TMO_LOAD = 18'(TIMEOUT_CYCLES - 1);
  logic [17:0] tmr;
  logic        tmo;

  assign tmo = (state != IDLE) && (tmr == '0);
`endif

  assign busy        = (state != IDLE);
  assign layer_id    = state;
  assign conv1_start = start_q[0];
  assign conv2_start = start_q[1];
  assign fc1_start   = start_q[2];
  assign fc2_start   = start_q[3];

  // Select the active engine's address/finish and map the address into the shared SRAM.
  always_comb begin
    loc_addr  = '0;
    base      = '0;
    size      = 17'd1;
    act_fin   = 1'b0;
    range_err = 1'b0;
    case (state)
      CONV1: begin loc_addr = conv1_raddr_w; base = C1_BASE; size = C1_SIZE; act_fin = conv1_finish; end
      CONV2: begin loc_addr = conv2_raddr_w; base = C2_BASE; size = C2_SIZE; act_fin = conv2_finish; end
      FC1:   begin loc_addr = fc1_raddr_w;   base = F1_BASE; size = F1_SIZE; act_fin = fc1_finish;   end
      FC2:   begin loc_addr = fc2_raddr_w;   base = F2_BASE; size = F2_SIZE; act_fin = fc2_finish;   end
      default: ;
    endcase
    if ({2'b00, loc_addr} >= size) begin
      sram_raddr_weight = base + size - 17'd1;
      range_err         = 1'b1;
    end else begin
      sram_raddr_weight = base + {2'b00, loc_addr};
    end
  end

  // Next-state logic; finish is masked during the start-pulse cycle of each layer.
  always_comb begin
    next_state = state;
    start_d    = '0;
    done_d     = 1'b0;
    img_inc    = 1'b0;
    batch_go   = 1'b0;
    fin_ok     = act_fin && (start_q == 4'b0000);
    case (state)
      IDLE: begin
        if (start) begin
          next_state = CONV1;
          batch_go   = 1'b1;
        end
      end
      CONV1: if (fin_ok) next_state = CONV2;
      CONV2: if (fin_ok) next_state = FC1;
      FC1:   if (fin_ok) next_state = FC2;
      FC2: begin
        if (fin_ok) begin
          if (image_cnt == LAST_IMG) begin
            next_state = IDLE;
            done_d     = 1'b1;
          end else begin
            next_state = CONV1;
            img_inc    = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
`ifdef LENET_SCHED_TIMEOUT_EN
    if (tmo && !fin_ok) begin
      next_state = IDLE;
      done_d     = 1'b0;
      img_inc    = 1'b0;
    end
`endif
    if (next_state != state) begin
      case (next_state)
        CONV1:   start_d = 4'b0001;
        CONV2:   start_d = 4'b0010;
        FC1:     start_d = 4'b0100;
        FC2:     start_d = 4'b1000;
        default: start_d = 4'b0000;
      endcase
    end
  end

  // State, start pulses, done, image counter and sticky address error.
  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= IDLE;
      start_q   <= '0;
      done      <= 1'b0;
      image_cnt <= '0;
      addr_err  <= 1'b0;
    end else begin
      state   <= next_state;
      start_q <= start_d;
      done    <= done_d;
      if (batch_go)
        image_cnt <= '0;
      else if (img_inc)
        image_cnt <= image_cnt + 16'd1;
      if (batch_go)
        addr_err <= 1'b0;
      else if (range_err)
        addr_err <= 1'b1;
    end
  end

`ifdef LENET_SCHED_TIMEOUT_EN
  // Watchdog down-counter reloaded on every state entry; terminal count aborts the batch.
  always_ff @(posedge clk) begin
    if (srst) begin
      tmr         <= TMO_LOAD;
      timeout_err <= 1'b0;
    end else begin
      if (next_state != state)
        tmr <= TMO_LOAD;
      else if (tmr != '0)
        tmr <= tmr - 18'd1;
      if (batch_go)
        timeout_err <= 1'b0;
      else if (tmo && !fin_ok)
        timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lenet_layer_sched.sv
// tb_lenet_layer_sched: randomized batches with engine models; expected
// layer/image order, start/done pulses and weight addresses come from
// plain loops and arithmetic over the layer base/size table.
`timescale 1ns/1ps
module tb_lenet_layer_sched;

  localparam int N_IMG = 3;

  logic        clk = 1'b0;
  logic        srst;
  logic        start;
  logic        busy, done;
  logic [2:0]  layer_id;
  logic [15:0] image_cnt;
  logic        conv1_start, conv2_start, fc1_start, fc2_start;
  logic [3:0]  fin;
  logic [14:0] ra [4];
  logic [16:0] sram_raddr_weight;
  logic        addr_err, timeout_err;

  int total = 0;
  int bad   = 0;
  int err_m = 0;
  int err_pend = 0;

  lenet_layer_sched #(
    .NUM_IMAGES(N_IMG),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .srst(srst),
    .start(start),
    .busy(busy),
    .done(done),
    .layer_id(layer_id),
    .image_cnt(image_cnt),
    .conv1_start(conv1_start),
    .conv2_start(conv2_start),
    .fc1_start(fc1_start),
    .fc2_start(fc2_start),
    .conv1_finish(fin[0]),
    .conv2_finish(fin[1]),
    .fc1_finish(fin[2]),
    .fc2_finish(fin[3]),
    .conv1_raddr_w(ra[0]),
    .conv2_raddr_w(ra[1]),
    .fc1_raddr_w(ra[2]),
    .fc2_raddr_w(ra[3]),
    .sram_raddr_weight(sram_raddr_weight),
    .addr_err(addr_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic int base_of(input int e);
    case (e)
      0: return 0;
      1: return 21;
      2: return 1023;
      default: return 17023;
    endcase
  endfunction

  function automatic int size_of(input int e);
    case (e)
      0: return 21;
      1: return 1002;
      2: return 16000;
      default: return 200;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (err_pend != 0) err_m = 1;
    err_pend = 0;
  endtask

  task automatic chk_regs(input int layer, input int img, input int stv, input int dn);
    chk("layer_id", 32'(layer_id), layer);
    chk("busy", 32'(busy), 32'(layer != 0));
    chk("starts", 32'({fc2_start, fc1_start, conv2_start, conv1_start}), stv);
    chk("done", 32'(done), dn);
    chk("addr_err", 32'(addr_err), err_m);
    chk("timeout_err", 32'(timeout_err), 0);
    if (img >= 0) chk("image_cnt", 32'(image_cnt), img);
  endtask

  // act = active engine index (0..3) or -1 for IDLE; forced >= 0 fixes the active address
  task automatic drive_and_check_addr(input int act, input int forced);
    int a;
    for (int e = 0; e < 4; e++) ra[e] = 15'($urandom_range(0, 32767));
    if (act >= 0) begin
      if (forced >= 0)
        a = forced;
      else if ($urandom_range(0, 3) == 0)
        a = $urandom_range(size_of(act), 32767);
      else
        a = $urandom_range(0, size_of(act) - 1);
      ra[act] = 15'(a);
      #1;
      chk("waddr", 32'(sram_raddr_weight),
          base_of(act) + ((a >= size_of(act)) ? size_of(act) - 1 : a));
      if (a >= size_of(act)) err_pend = 1;
    end else begin
      #1;
      chk("waddr_idle", 32'(sram_raddr_weight), 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk_regs(0, -1, 0, 0);
      start = 1'b0;
      fin   = 4'($urandom_range(0, 15));
      drive_and_check_addr(-1, -1);
      tick();
    end
    fin = '0;
  endtask

  // abort_layer: 0 = full batch, otherwise reset in the first dwell cycle of that layer
  task automatic run_batch(input int abort_layer, input bit directed);
    int dwell;
    int forced;
    fin   = '0;
    start = 1'b1;
    drive_and_check_addr(-1, -1);
    tick();
    start = 1'b0;
    err_m = 0;
    for (int img = 0; img < N_IMG; img++) begin
      for (int l = 1; l <= 4; l++) begin
        dwell = directed ? 2 : $urandom_range(1, 5);
        chk_regs(l, img, 1 << (l - 1), 0);
        fin = '0;
        if ($urandom_range(0, 1) == 1) fin[l-1] = 1'b1;
        start = 1'($urandom_range(0, 1));
        drive_and_check_addr(l - 1, -1);
        tick();
        for (int d = 0; d < dwell; d++) begin
          chk_regs(l, img, 0, 0);
          if (abort_layer == l) begin
            srst  = 1'b1;
            fin   = 4'($urandom_range(0, 15));
            start = 1'($urandom_range(0, 1));
            drive_and_check_addr(l - 1, -1);
            tick();
            srst = 1'b0; start = 1'b0; fin = '0;
            err_m = 0; err_pend = 0;
            chk_regs(0, 0, 0, 0);
            drive_and_check_addr(-1, -1);
            return;
          end
          fin = 4'($urandom_range(0, 15));
          fin[l-1] = 1'b0;
          start = 1'($urandom_range(0, 1));
          forced = -1;
          if (directed && l == 2 && d == 0) forced = 5;
          if (directed && l == 4 && d == 0) forced = 199;
          if (directed && l == 4 && d == 1) forced = 200;
          drive_and_check_addr(l - 1, forced);
          tick();
        end
        chk_regs(l, img, 0, 0);
        fin = 4'($urandom_range(0, 15));
        fin[l-1] = 1'b1;
        start = 1'($urandom_range(0, 1));
        drive_and_check_addr(l - 1, -1);
        tick();
        fin = '0;
        start = 1'b0;
      end
    end
    chk_regs(0, -1, 0, 1);
    drive_and_check_addr(-1, -1);
    tick();
    chk_regs(0, -1, 0, 0);
  endtask

`ifdef LENET_SCHED_TIMEOUT_EN
  task automatic run_timeout();
    int dn = 0;
    for (int e = 0; e < 4; e++) ra[e] = '0;
    fin = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    fin[0] = 1'b1;
    tick();
    fin = '0;
    for (int c = 1; c <= 50; c++) begin
      chk("tmo_in_conv2", 32'(layer_id), 2);
      chk("tmo_err_early", 32'(timeout_err), 0);
      tick();
      if (done) dn++;
    end
    chk("tmo_state_idle", 32'(layer_id), 0);
    chk("tmo_err_set", 32'(timeout_err), 1);
    chk("tmo_no_done", 32'(dn), 0);
  endtask
`endif

  initial begin
    srst  = 1'b1;
    start = 1'b0;
    fin   = '0;
    for (int e = 0; e < 4; e++) ra[e] = '0;
    repeat (3) tick();
    chk_regs(0, 0, 0, 0);
    drive_and_check_addr(-1, -1);
    srst = 1'b0;
    idle(3);
    run_batch(0, 1'b1);
    idle(2);
    for (int b = 0; b < 3; b++) begin
      run_batch(0, 1'b0);
      idle($urandom_range(1, 3));
    end
    run_batch(3, 1'b0);
    idle(2);
    run_batch(0, 1'b0);
    idle(2);
`ifdef LENET_SCHED_TIMEOUT_EN
    run_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
